pwm_duty_sequencer: RTL and testbench
=====================================

// Module: pwm_duty_sequencer
// PURPOSE
//  Controller that sequences the duty setting of the PWM datapath (counter/comparator).
//  Converts raw incr/decr buttons into a saturating target duty.
//  Applies soft-start and soft-stop ramps, and updates the datapath duty only at PWM period
//  boundaries, giving glitch-free output. Sits between the user buttons/enable and the PWM core.
// PARAMETERS
//  DUTY_W     4   width of duty values
//  DUTY_MAX   10  max duty (= PWM period in counts); target saturates at [0, DUTY_MAX]
//  DUTY_RESET 5   target_duty value after reset
//  RAMP_DIV   4   PWM periods per one-step ramp increment/decrement (>=1)
// PORTS
//  clock        in   1       single system clock, all logic posedge
//  reset        in   1       synchronous, active-high
//  enable       in   1       level; 1 = output on (ramp up), 0 = output off (ramp down)
//  incr_duty    in   1       raw async button, raise target
//  decr_duty    in   1       raw async button, lower target
//  period_wrap  in   1       1-cycle pulse from PWM core, last count of a PWM period
//  duty_out     out  DUTY_W  duty applied to PWM comparator
//  duty_load    out  1       1-cycle pulse, high in the cycle duty_out holds a new value
//  target_duty  out  DUTY_W  current user target
//  state        out  2       FSM state: 0 OFF, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
//  busy         out  1       1 in RAMP_UP or RAMP_DOWN
// BEHAVIOUR
//  Reset (synchronous) takes effect at the next edge: state=OFF, duty_out=0, duty_load=0,
//   target_duty=DUTY_RESET, busy=0, ramp counter=0, sync/edge regs=0.
//  Reset mid-ramp aborts immediately; no ramp continues.
//  Buttons: 2-FF synchroniser plus rising-edge detect.
//   A rising input sampled at edge N updates target_duty at edge N+3.
//   One step per press. Increment saturates at DUTY_MAX; decrement saturates at 0.
//   Simultaneous incr and decr edges in the same cycle: both ignored.
//   Target changes are accepted in every state.
//  Ramp tick: the ramp counter counts period_wrap pulses while in RAMP_UP or RAMP_DOWN.
//   tick = period_wrap & (cnt==RAMP_DIV-1). On tick, cnt wraps to 0.
//   cnt clears on every state change.
//  All duty_out changes occur only at an edge where period_wrap=1.
//   duty_load=1 during the following cycle, only if the value changed.
//  FSM:
//   OFF: duty_out=0. enable=1 -> RAMP_UP.
//   RAMP_UP:
//    - on tick, if duty_out<target_duty then duty_out+1.
//    - if duty_out>=target_duty (including target lowered mid-ramp) -> RUN.
//    - enable=0 -> RAMP_DOWN, which takes priority.
//   RUN:
//    - on period_wrap, duty_out<=target_duty in a single jump.
//    - enable=0 -> RAMP_DOWN.
//   RAMP_DOWN:
//    - on tick, duty_out-1.
//    - duty_out==0 -> OFF.
//    - enable=1 -> RAMP_UP, resuming from the current duty_out with no jump.
//  Arithmetic: unsigned DUTY_W. Compare and step are guarded, so no wrap-around (0-1, MAX+1) is possible.
//  busy is combinational from the state register.
//  period_wrap and tick coinciding with a state transition: the transition wins; no duty step that cycle.
// STRUCTURE
//  Shared header pwm_ctrl_defs.vh holds:
//   - state encodings ST_OFF/ST_RAMP_UP/ST_RUN/ST_RAMP_DOWN
//   - default DUTY_W, DUTY_MAX
//  One sub-module pwm_btn_edge (clock, reset, btn_raw -> press_pulse): 2-FF sync plus edge detect.
//   Instantiated twice.
//  FSM, target register and ramp counter are in this module.
// TESTING (DUTY_MAX=10, RAMP_DIV=4, period_wrap every 10 clocks)
//  1 Reset, then enable=1 with target=5: duty_out steps 0->1->...->5, one step every 4 wraps.
//    state goes RAMP_UP -> RUN after the 5th step. duty_load pulses exactly 5 times.
//  2 In RUN at 5, press incr 7 times: target_duty saturates at 10.
//    duty_out changes only at a wrap edge. Press decr 12 times: target_duty=0, no underflow.
//  3 Pulse incr and decr together for 3 cycles: target_duty unchanged. Held button: one step only.
//  4 In RUN at 8, drop enable: RAMP_DOWN, duty_out 8->0 stepping every 4 wraps, then OFF, busy=0.
//    Re-raise enable at duty 3: RAMP_UP continues 3->4 with no jump.
//  5 During RAMP_UP at duty 4, lower target to 2: next edge state=RUN.
//    At the next wrap duty_out=2.
//  6 Assert reset mid-RAMP_UP: next edge duty_out=0, state=OFF, target=5, duty_load=0.

Source files
------------

// File: rtl/pwm_duty_sequencer_pkg.sv
// pwm_duty_sequencer_pkg: shared state encoding and default widths for the PWM duty sequencer
package pwm_duty_sequencer_pkg;
  localparam int DUTY_W_DEF = 4;
  localparam int DUTY_MAX_DEF = 10;
  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;
endpackage

// File: rtl/pwm_duty_sequencer_btn_edge.sv
// pwm_btn_edge: 2-FF synchroniser plus registered rising-edge detect for a raw button
module pwm_btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);
  logic [2:0] sh;
  always_ff @(posedge clock) begin
    if (reset) begin
      sh <= '0;
      press_pulse <= 1'b0;
    end else begin
      sh <= {sh[1:0], btn_raw};
      press_pulse <= sh[1] & ~sh[2];
    end
  end
endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: saturating target from buttons, soft-start/stop ramps, period-aligned duty updates
import pwm_duty_sequencer_pkg::*;

module pwm_duty_sequencer #(
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int DUTY_MAX   = DUTY_MAX_DEF,
  parameter int DUTY_RESET = 5,
  parameter int RAMP_DIV   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              incr_duty,
  input  logic              decr_duty,
  input  logic              period_wrap,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_load,
  output logic [DUTY_W-1:0] target_duty,
  output logic [1:0]        state,
  output logic              busy
);
  localparam int CNT_W = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [DUTY_W-1:0] MAX_V = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] RST_V = DUTY_W'(DUTY_RESET);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAMP_DIV - 1);
  state_t st;
  logic [CNT_W-1:0] cnt;
  logic incr_p, decr_p, tick;
  pwm_btn_edge u_incr (.clock(clock), .reset(reset), .btn_raw(incr_duty), .press_pulse(incr_p));
  pwm_btn_edge u_decr (.clock(clock), .reset(reset), .btn_raw(decr_duty), .press_pulse(decr_p));
  assign tick  = period_wrap && cnt == LAST_CNT;
  assign busy  = st == ST_RAMP_UP || st == ST_RAMP_DOWN;
  assign state = st;
  always_ff @(posedge clock) begin
    if (reset)
      target_duty <= RST_V;
    else if (incr_p && !decr_p && target_duty < MAX_V)
      target_duty <= target_duty + 1'b1;
    else if (decr_p && !incr_p && target_duty != '0)
      target_duty <= target_duty - 1'b1;
  end
  // State changes take precedence over any duty step; cnt restarts on every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= ST_OFF;
      duty_out <= '0;
      duty_load <= 1'b0;
      cnt <= '0;
    end else begin
      duty_load <= 1'b0;
      case (st)
        ST_OFF: if (enable) begin
          st <= ST_RAMP_UP;
          cnt <= '0;
        end
        ST_RAMP_UP: if (!enable) begin
          st <= ST_RAMP_DOWN;
          cnt <= '0;
        end else if (duty_out >= target_duty) begin
          st <= ST_RUN;
          cnt <= '0;
        end else if (period_wrap) begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            duty_out <= duty_out + 1'b1;
            duty_load <= 1'b1;
          end
        end
        ST_RUN: if (!enable) begin
          st <= ST_RAMP_DOWN;
          cnt <= '0;
        end else if (period_wrap && duty_out != target_duty) begin
          duty_out <= target_duty;
          duty_load <= 1'b1;
        end
        ST_RAMP_DOWN: if (enable) begin
          st <= ST_RAMP_UP;
          cnt <= '0;
        end else if (duty_out == '0) begin
          st <= ST_OFF;
          cnt <= '0;
        end else if (period_wrap) begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            duty_out <= duty_out - 1'b1;
            duty_load <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer: directed checks of ramps, target saturation, period-aligned updates and reset
module tb_pwm_duty_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic incr_duty = 1'b0;
  logic decr_duty = 1'b0;
  logic period_wrap;
  logic [3:0] duty_out, target_duty;
  logic duty_load, busy;
  logic [1:0] state;
  int n_checks = 0;
  int n_fail = 0;
  int wcnt = 0;
  int bad_chg = 0;
  int bad_load = 0;
  int load_cnt = 0;
  logic mon_en = 1'b0;
  logic wrap_q = 1'b0;
  logic rst_q = 1'b0;
  logic [3:0] last_duty = '0;
  pwm_duty_sequencer #(.DUTY_W(4), .DUTY_MAX(10), .DUTY_RESET(5), .RAMP_DIV(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .incr_duty(incr_duty),
    .decr_duty(decr_duty), .period_wrap(period_wrap), .duty_out(duty_out),
    .duty_load(duty_load), .target_duty(target_duty), .state(state), .busy(busy)
  );
  always #5 clock = ~clock;
  assign period_wrap = wcnt == 9;
  always @(posedge clock) begin
    wcnt <= wcnt == 9 ? 0 : wcnt + 1;
    wrap_q <= period_wrap;
    rst_q <= reset;
  end
  // Any duty change must follow a wrap edge and be flagged by duty_load exactly then.
  always @(negedge clock) begin
    if (mon_en) begin
      if (duty_out != last_duty && !wrap_q && !rst_q) bad_chg++;
      if (!rst_q && duty_load != (duty_out != last_duty)) bad_load++;
      if (duty_load) load_cnt++;
    end
    last_duty = duty_out;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic press(input logic inc, input logic dec);
    @(negedge clock);
    incr_duty = inc;
    decr_duty = dec;
    repeat (3) @(negedge clock);
    incr_duty = 1'b0;
    decr_duty = 1'b0;
    repeat (4) @(negedge clock);
  endtask
  task automatic wait_change(input string tag, input int budget, output int n);
    logic [3:0] d0;
    d0 = duty_out;
    n = 0;
    while (duty_out == d0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_changed"}, int'(duty_out != d0), 1);
  endtask
  task automatic wait_duty(input string tag, input int val, input int budget);
    int n;
    n = 0;
    while (int'(duty_out) != val && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, int'(duty_out), val);
  endtask
  initial begin
    int n, lc0;
    repeat (3) @(negedge clock);
    check("rst_state", int'(state), 0);
    check("rst_duty", int'(duty_out), 0);
    check("rst_target", int'(target_duty), 5);
    check("rst_busy", int'(busy), 0);
    check("rst_load", int'(duty_load), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    lc0 = load_cnt;
    enable = 1'b1;
    @(negedge clock);
    check("t1_ramp_up", int'(state), 1);
    check("t1_busy", int'(busy), 1);
    for (int k = 1; k <= 5; k++) begin
      wait_change("t1_step", 60, n);
      check("t1_duty", int'(duty_out), k);
      if (k > 1) check("t1_gap", n, 40);
    end
    check("t1_still_ramp", int'(state), 1);
    @(negedge clock);
    check("t1_run", int'(state), 2);
    check("t1_loads", load_cnt - lc0, 5);
    for (int k = 0; k < 7; k++) press(1'b1, 1'b0);
    check("t2_target_sat", int'(target_duty), 10);
    wait_duty("t2_duty_max", 10, 30);
    for (int k = 0; k < 12; k++) press(1'b0, 1'b1);
    check("t2_target_zero", int'(target_duty), 0);
    wait_duty("t2_duty_zero", 0, 30);
    check("t2_run", int'(state), 2);
    for (int k = 0; k < 8; k++) press(1'b1, 1'b0);
    check("t3_target8", int'(target_duty), 8);
    press(1'b1, 1'b1);
    check("t3_both", int'(target_duty), 8);
    @(negedge clock);
    incr_duty = 1'b1;
    repeat (20) @(negedge clock);
    incr_duty = 1'b0;
    repeat (4) @(negedge clock);
    check("t3_held", int'(target_duty), 9);
    press(1'b0, 1'b1);
    check("t3_back8", int'(target_duty), 8);
    wait_duty("t4_run8", 8, 30);
    enable = 1'b0;
    @(negedge clock);
    check("t4_ramp_down", int'(state), 3);
    check("t4_busy", int'(busy), 1);
    for (int k = 7; k >= 3; k--) begin
      wait_change("t4_step", 60, n);
      check("t4_duty", int'(duty_out), k);
      if (k < 7) check("t4_gap", n, 40);
    end
    enable = 1'b1;
    @(negedge clock);
    check("t4_reraise_state", int'(state), 1);
    check("t4_no_jump", int'(duty_out), 3);
    wait_change("t4_resume", 60, n);
    check("t4_resume_duty", int'(duty_out), 4);
    for (int k = 0; k < 3; k++) press(1'b0, 1'b1);
    check("t5_target5", int'(target_duty), 5);
    check("t5_still_ramp", int'(state), 1);
    press(1'b0, 1'b1);
    check("t5_target4", int'(target_duty), 4);
    check("t5_run", int'(state), 2);
    check("t5_duty_hold", int'(duty_out), 4);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("t5_target2", int'(target_duty), 2);
    wait_duty("t5_duty2", 2, 30);
    check("t5_run2", int'(state), 2);
    enable = 1'b0;
    wait_duty("t4_down0", 0, 200);
    @(negedge clock);
    check("t4_off", int'(state), 0);
    check("t4_off_busy", int'(busy), 0);
    enable = 1'b1;
    wait_change("t6_step", 60, n);
    check("t6_duty1", int'(duty_out), 1);
    check("t6_ramp", int'(state), 1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    check("t6_duty", int'(duty_out), 0);
    check("t6_state", int'(state), 0);
    check("t6_target", int'(target_duty), 5);
    check("t6_load", int'(duty_load), 0);
    check("t6_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("t6_stays_off", int'(state), 0);
    check("mon_chg_outside_wrap", bad_chg, 0);
    check("mon_load_mismatch", bad_load, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
